// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: zero-latency hits in IDLE,
// block-by-block refill from the RAM port with a ramwait handshake.
module icache #(
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        ramREN,
    output logic [31:0] ramaddr,
    input  logic [31:0] ramload,
    input  logic        ramwait,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int WO = $clog2(BLOCK_WORDS);
    localparam int IX = $clog2(SETS);
    localparam int TW = 30 - WO - IX;
    localparam int KW = (WO > 0) ? WO : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BLOCK_WORDS - 1);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t        r_state;
    logic [SETS-1:0] r_valid;
    logic [TW-1:0] r_tag  [SETS];
    logic [31:0]   r_data [SETS][BLOCK_WORDS];
    logic [TW-1:0] r_base_tag;
    logic [IX-1:0] r_base_idx;
    logic [KW-1:0] r_k;
    logic [31:0]   r_hit_count;
    logic [31:0]   r_miss_count;

    logic [IX-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic [KW-1:0] w_off;
    logic          w_lookup;
    logic          w_ihit;
    logic          w_fill_we;
    logic          w_fill_last;
    logic          w_unused;

    assign w_idx    = imemaddr[2+WO +: IX];
    assign w_tag    = imemaddr[2+WO+IX +: TW];
    assign w_unused = ^imemaddr[1:0];

    generate
        if (WO > 0) begin : g_off
            assign w_off = imemaddr[2 +: KW];
        end else begin : g_no_off
            assign w_off = '0;
        end
    endgenerate

    assign w_lookup    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_ihit      = (r_state == S_IDLE) && imemREN && !flush && !RST && w_lookup;
    assign w_fill_we   = (r_state == S_FILL) && !ramwait && !flush && !RST;
    assign w_fill_last = w_fill_we && (r_k == K_LAST);

    assign ihit       = w_ihit;
    assign imemload   = w_ihit ? r_data[w_idx][w_off] : '0;
    assign ramREN     = (r_state == S_FILL) && !RST;
    assign ramaddr    = ramREN ? ({r_base_tag, r_base_idx, {(WO+2){1'b0}}} | (32'(r_k) << 2)) : '0;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Control state; valid bits are cleared by reset, flush in either state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_k          <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_ihit)
                r_hit_count <= r_hit_count + 32'd1;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (imemREN && !w_lookup) begin
                        r_base_tag   <= w_tag;
                        r_base_idx   <= w_idx;
                        r_k          <= '0;
                        r_miss_count <= r_miss_count + 32'd1;
                        r_state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (flush) begin
                        r_valid <= '0;
                        r_state <= S_IDLE;
                    end else if (w_fill_last) begin
                        r_valid[r_base_idx] <= 1'b1;
                        r_state             <= S_IDLE;
                    end else if (w_fill_we) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity is tracked by r_valid
    always_ff @(posedge CLK) begin
        if (w_fill_we)
            r_data[r_base_idx][r_k] <= ramload;
        if (w_fill_last)
            r_tag[r_base_idx] <= r_base_tag;
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, spatial hit, conflict, RAM stall,
// flush in IDLE and FILL, and reset during a fill.
module tb_icache;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        flush = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        ramREN;
    logic [31:0] ramaddr;
    logic [31:0] ramload;
    logic        ramwait = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_vec = 0;
    int n_err = 0;

    icache #(.SETS(16), .BLOCK_WORDS(2)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .flush(flush), .ihit(ihit), .imemload(imemload), .ramREN(ramREN),
        .ramaddr(ramaddr), .ramload(ramload), .ramwait(ramwait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    // RAM contents: two fixed words at 0x100/0x104, otherwise 0xD0000000 | addr
    always_comb begin
        if (ramaddr == 32'h100)      ramload = 32'hACE1ACE1;
        else if (ramaddr == 32'h104) ramload = 32'hACE2ACE2;
        else                         ramload = 32'hD000_0000 | ramaddr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs at the falling edge, then settle before checks
    task automatic drive(input logic rst, input logic ren, input logic [31:0] addr,
                         input logic fl, input logic rw);
        @(negedge CLK);
        RST      = rst;
        imemREN  = ren;
        imemaddr = addr;
        flush    = fl;
        ramwait  = rw;
        #1;
    endtask

    initial begin
        // Reset state
        drive(1, 1, 32'h100, 0, 0);
        chk1("rst_ihit", ihit, 1'b0);
        chk("rst_load", imemload, 32'h0);
        chk1("rst_ramREN", ramREN, 1'b0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);

        // 1: cold miss at 0x100
        drive(0, 1, 32'h100, 0, 0);
        chk1("s1_c0_ihit", ihit, 1'b0);
        chk1("s1_c0_ramREN", ramREN, 1'b0);
        drive(0, 1, 32'h100, 0, 0);
        chk1("s1_c1_ramREN", ramREN, 1'b1);
        chk("s1_c1_ramaddr", ramaddr, 32'h100);
        chk1("s1_c1_ihit", ihit, 1'b0);
        chk("s1_c1_misses", miss_count, 32'd1);
        drive(0, 1, 32'h100, 0, 0);
        chk1("s1_c2_ramREN", ramREN, 1'b1);
        chk("s1_c2_ramaddr", ramaddr, 32'h104);
        drive(0, 1, 32'h100, 0, 0);
        chk1("s1_c3_ihit", ihit, 1'b1);
        chk("s1_c3_load", imemload, 32'hACE1ACE1);
        chk1("s1_c3_ramREN", ramREN, 1'b0);
        chk("s1_c3_misses", miss_count, 32'd1);

        // 2: spatial hit on the other word of the block
        drive(0, 1, 32'h104, 0, 0);
        chk1("s2_ihit", ihit, 1'b1);
        chk("s2_load", imemload, 32'hACE2ACE2);
        chk1("s2_ramREN", ramREN, 1'b0);
        drive(0, 0, 32'h104, 0, 0);
        chk("s2_hits", hit_count, 32'd2);
        chk1("s2_idle_ihit", ihit, 1'b0);
        chk("s2_idle_load", imemload, 32'h0);

        // 3: conflict on index 0
        drive(0, 1, 32'h180, 0, 0);
        chk1("s3_miss_ihit", ihit, 1'b0);
        drive(0, 1, 32'h180, 0, 0);
        chk("s3_fill0", ramaddr, 32'h180);
        drive(0, 1, 32'h180, 0, 0);
        chk("s3_fill1", ramaddr, 32'h184);
        drive(0, 1, 32'h180, 0, 0);
        chk1("s3_hit", ihit, 1'b1);
        chk("s3_hit_load", imemload, 32'hD0000180);
        drive(0, 1, 32'h100, 0, 0);
        chk1("s3_evicted", ihit, 1'b0);
        drive(0, 1, 32'h100, 0, 0);
        chk("s3_misses", miss_count, 32'd3);
        chk("s3_refill0", ramaddr, 32'h100);
        drive(0, 1, 32'h100, 0, 0);
        chk("s3_refill1", ramaddr, 32'h104);
        drive(0, 1, 32'h100, 0, 0);
        chk("s3_rehit_load", imemload, 32'hACE1ACE1);
        chk("s3_hits", hit_count, 32'd3);

        // 4: three wait cycles before each RAM word
        drive(0, 1, 32'h200, 0, 1);
        chk1("s4_c0_ihit", ihit, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 32'h200, 0, (i % 4) != 0);
            chk1("s4_ramREN", ramREN, 1'b1);
            chk("s4_ramaddr", ramaddr, (i <= 4) ? 32'h200 : 32'h204);
            chk1("s4_ihit", ihit, 1'b0);
        end
        drive(0, 1, 32'h200, 0, 0);
        chk1("s4_c9_ihit", ihit, 1'b1);
        chk("s4_c9_load", imemload, 32'hD0000200);
        chk("s4_misses", miss_count, 32'd4);

        // 5a: flush with a request in the same cycle, then the valid line misses
        drive(0, 1, 32'h200, 1, 0);
        chk1("s5a_flush_ihit", ihit, 1'b0);
        chk("s5a_hits", hit_count, 32'd5);
        drive(0, 1, 32'h200, 0, 0);
        chk1("s5a_after_flush", ihit, 1'b0);
        chk("s5a_misses_pre", miss_count, 32'd4);

        // 5b: flush during a stalled fill aborts it
        drive(0, 1, 32'h200, 1, 1);
        chk1("s5b_fill_ramREN", ramREN, 1'b1);
        chk("s5b_fill_ramaddr", ramaddr, 32'h200);
        chk("s5b_misses", miss_count, 32'd5);
        drive(0, 1, 32'h200, 0, 0);
        chk1("s5b_abort_ramREN", ramREN, 1'b0);
        chk1("s5b_retry_ihit", ihit, 1'b0);
        drive(0, 1, 32'h200, 0, 0);
        chk("s5b_refill_misses", miss_count, 32'd6);
        chk("s5b_refill0", ramaddr, 32'h200);
        drive(0, 1, 32'h200, 0, 0);
        chk("s5b_refill1", ramaddr, 32'h204);
        drive(0, 1, 32'h204, 0, 0);
        chk1("s5b_hit", ihit, 1'b1);
        chk("s5b_hit_load", imemload, 32'hD0000204);

        // 6: reset in the middle of a fill
        drive(0, 1, 32'h108, 0, 0);
        chk1("s6_miss", ihit, 1'b0);
        chk("s6_hits", hit_count, 32'd6);
        drive(0, 1, 32'h108, 0, 0);
        chk("s6_fill0", ramaddr, 32'h108);
        drive(1, 1, 32'h108, 0, 0);
        chk1("s6_rst_ramREN", ramREN, 1'b0);
        chk("s6_rst_ramaddr", ramaddr, 32'h0);
        chk1("s6_rst_ihit", ihit, 1'b0);
        drive(0, 1, 32'h200, 0, 0);
        chk1("s6_post_ramREN", ramREN, 1'b0);
        chk1("s6_post_ihit", ihit, 1'b0);
        chk("s6_post_hits", hit_count, 32'd0);
        chk("s6_post_misses", miss_count, 32'd0);
        drive(0, 1, 32'h200, 0, 0);
        chk("s6_refetch_misses", miss_count, 32'd1);
        chk("s6_refetch_addr", ramaddr, 32'h200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache that answers the fetch stage's instruction-memory requests. Fetch presents `imemaddr`/`imemREN` and stalls until `ihit`, consuming `imemload`. Misses are filled block-by-block from the lower-level RAM port with a `ramwait` handshake. The cache sits between fetch and the memory arbiter, and exposes hit and miss counters for performance runs.

## Interface

Parameters:
- `SETS`, 16: number of lines; power of two, at least 2.
- `BLOCK_WORDS`, 2: 32-bit words per line; power of two, at least 1.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `imemREN` in 1: fetch read request.
- `imemaddr` in 32: byte address of the request; word-aligned, and `[1:0]` is ignored.
- `flush` in 1: invalidate all lines.
- `ihit` out 1: `imemload` is valid for the current request.
- `imemload` out 32: instruction word; 0 whenever `ihit`=0.
- `ramREN` out 1: RAM read request.
- `ramaddr` out 32: RAM word byte-address.
- `ramload` in 32: RAM read data; valid in a cycle with `ramREN`=1 and `ramwait`=0.
- `ramwait` in 1: RAM not ready; the request is held.
- `hit_count` out 32: number of cycles in which `ihit`=1.
- `miss_count` out 32: number of fills started.

## Operation

Address split, with WO = log2(BLOCK_WORDS) and IX = log2(SETS):
- word offset = `[2+WO-1:2]`
- index = `[2+WO+IX-1:2+WO]`
- tag = the remaining upper bits

With the defaults this is offset bit 2, index bits [6:3], tag bits [31:7].

Per-line state: valid bit, tag, and BLOCK_WORDS data words.

State machine: IDLE and FILL.
- **IDLE**
  - `ihit` = `imemREN` & !`flush` & !`RST` & valid[index] & (tag match). This is combinational.
  - On a hit, `imemload` = the addressed data word.
  - If `imemREN` & !hit & !`flush`:
    - latch the block base address (offset bits cleared);
    - clear the word counter k;
    - increment `miss_count`;
    - go to FILL.
  - If `flush`: clear every valid bit and stay in IDLE. The request is not looked up that cycle.
- **FILL**
  - `ramREN`=1 and `ramaddr` = base + 4·k; `ihit`=0.
  - In each cycle with `ramwait`=0:
    - write `ramload` into word k of the latched index;
    - if k is the last word: write the tag, set valid, go to IDLE;
    - otherwise increment k.
  - Fill address is latched. Changes to `imemaddr` or a drop of `imemREN` during FILL do not alter the fill. The fill completes, and the new request is looked up in IDLE.
  - `flush` in FILL: abort. Clear all valid bits (the partial line is not validated) and go to IDLE. `ramREN` is 0 from the next cycle. The RAM port is request-level, so dropping `ramREN` is legal.
- Replacement: a fill overwrites the indexed line unconditionally. There is no dirty state, since the cache is read-only.
- Counters wrap modulo 2^32.
  - `hit_count` increments each cycle `ihit`=1.
  - `miss_count` increments on the IDLE→FILL transition.

## Timing

Reset (`RST`=1 at an edge):
- all valid bits cleared, state IDLE, k=0, counters 0.
- while `RST`=1: `ihit`=0, `imemload`=0, `ramREN`=0, `ramaddr`=0.
- data and tag arrays need no reset.

Latencies:
- Hit: 0 cycles; `ihit` is in the same cycle as the request.
- Miss with `ramwait`=0 throughout: the request misses in cycle 0. FILL spans cycles 1…BLOCK_WORDS. `ihit` comes in cycle BLOCK_WORDS+1, which is cycle 3 for the defaults.
- Each cycle of `ramwait`=1 during FILL adds one cycle.
- `ramaddr` is stable while `ramwait`=1.

Boundary cases:
- The line becomes valid at the edge that accepts the last word. The first lookup able to hit it is in the following cycle.
- `flush` and `imemREN` in the same cycle: flush wins and `ihit`=0.
- `RST` mid-fill: the next cycle shows the reset values, and the line is not validated.
- Back-to-back requests to the same block: one miss, then hits every cycle.

## Test plan

1. **Cold miss.** Reset, then `imemREN`=1 at 0x100. RAM returns 0xACE1ACE1 at 0x100 and 0xACE2ACE2 at 0x104, with `ramwait`=0.
   - Required: `ramREN` in cycles 1–2 with `ramaddr` 0x100 then 0x104.
   - `ihit`=1 with `imemload`=0xACE1ACE1 in cycle 3.
   - `miss_count`=1.
2. **Spatial hit.** After scenario 1, request 0x104.
   - Required: `ihit`=1 in the same cycle with 0xACE2ACE2, `ramREN`=0, `hit_count`=2.
3. **Conflict.** Request 0x180 (same index 0, new tag).
   - Required: a miss and a fill from 0x180/0x184.
   - Then 0x100 misses again; `miss_count`=3.
4. **RAM stall.** Cold miss at 0x200 with `ramwait`=1 for 3 cycles before each word.
   - Required: `ramaddr` holds 0x200 during cycles 1–4 and 0x204 during cycles 5–8.
   - `ihit` in cycle 9.
5. **Flush.**
   - Flush after the line 0x100 is valid: the next 0x100 request misses.
   - Flush in FILL with `ramwait`=1: `ramREN`=0 the next cycle, state IDLE, and the retried address misses again.
6. **Reset mid-fill.** Assert `RST` during FILL.
   - Required next cycle: `ramREN`=0, `ihit`=0, both counters 0.
   - The prior line misses afterwards.
